// File: rtl/matrix_stream_engine_if.sv
// Byte-stream interface of matrix_stream_engine: UART rx/tx handshake plus status flags.
interface matrix_stream_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [2:0] state;
  logic       busy;
  logic       err_size;
  logic       done;

  modport slave  (input  rx_data, rx_valid, tx_busy,
                  output tx_data, tx_start, state, busy, err_size, done);
  modport master (output rx_data, rx_valid, tx_busy,
                  input  tx_data, tx_start, state, busy, err_size, done);
endinterface

// File: rtl/matrix_stream_engine.sv
// Receives N, A, B over a byte stream, computes C = A x B with one MAC, streams C back LSB-first.
// Optional: define MSE_CHECKSUM_EN to append an XOR checksum byte after the result bytes.
module matrix_stream_engine #(
  parameter int MAX_N  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  matrix_stream_engine_if.slave  bus
);
  localparam int RES_BYTES = (ACC_W + 7) / 8;
  localparam int NN_MAX    = MAX_N * MAX_N;
  localparam int IDX_W     = (NN_MAX > 1) ? $clog2(NN_MAX) : 1;
  localparam int N_W       = $clog2(MAX_N + 1);
  localparam int W2        = 2 * N_W;
  localparam int PW        = 2 * DATA_W;
  localparam int B_W       = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam logic [7:0]     MAX_N8    = 8'(MAX_N);
  localparam logic [B_W-1:0] BYTE_LAST = B_W'(RES_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, RX_A = 3'd1, RX_B = 3'd2, COMPUTE = 3'd3, SEND = 3'd4, SEND_WAIT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d, ci_q, ci_d, cj_q, cj_d, ck_q, ck_d;
  logic [IDX_W-1:0] k_q, k_d, elem_q, elem_d;
  logic [B_W-1:0]   byte_q, byte_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       tx_data_q, tx_data_d, chk_q, chk_d;
  logic             tx_start_q, tx_start_d, err_q, err_d, done_q, done_d;
  logic             first_q, first_d, last_q, last_d, chk_ph_q, chk_ph_d;

  logic [DATA_W-1:0] a_mem [2**IDX_W];
  logic [DATA_W-1:0] b_mem [2**IDX_W];
  logic [ACC_W-1:0]  c_mem [2**IDX_W];

  logic                   a_we, b_we, c_we;
  logic [W2-1:0]          nn;
  logic [IDX_W-1:0]       nn_m1, a_idx, b_idx, c_idx;
  logic [N_W-1:0]         n_m1;
  logic [PW-1:0]          prod;
  logic [RES_BYTES*8-1:0] cword;
  logic [7:0]             res_byte;

  // Element addressing is row-major with the runtime N as the row stride.
  always_comb begin
    nn       = W2'(n_q) * W2'(n_q);
    nn_m1    = IDX_W'(nn - 1);
    n_m1     = n_q - N_W'(1);
    a_idx    = IDX_W'(W2'(ci_q) * W2'(n_q) + W2'(ck_q));
    b_idx    = IDX_W'(W2'(ck_q) * W2'(n_q) + W2'(cj_q));
    c_idx    = IDX_W'(W2'(ci_q) * W2'(n_q) + W2'(cj_q));
    prod     = PW'(a_mem[a_idx]) * PW'(b_mem[b_idx]);
    cword    = '0;
    cword[ACC_W-1:0] = c_mem[elem_q];
    res_byte = 8'(cword >> {byte_q, 3'b000});
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    ci_d       = ci_q;
    cj_d       = cj_q;
    ck_d       = ck_q;
    acc_d      = acc_q;
    elem_d     = elem_q;
    byte_d     = byte_q;
    chk_d      = chk_q;
    chk_ph_d   = chk_ph_q;
    last_d     = last_q;
    first_d    = first_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    c_we       = 1'b0;
    unique case (state_q)
      IDLE: if (bus.rx_valid) begin
        if (bus.rx_data != 8'd0 && bus.rx_data <= MAX_N8) begin
          n_d     = N_W'(bus.rx_data);
          k_d     = '0;
          state_d = RX_A;
        end else begin
          err_d = 1'b1;
        end
      end
      RX_A: if (bus.rx_valid) begin
        a_we = 1'b1;
        if (k_q == nn_m1) begin
          k_d     = '0;
          state_d = RX_B;
        end else k_d = k_q + IDX_W'(1);
      end
      RX_B: if (bus.rx_valid) begin
        b_we = 1'b1;
        if (k_q == nn_m1) begin
          k_d     = '0;
          ci_d    = '0;
          cj_d    = '0;
          ck_d    = '0;
          state_d = COMPUTE;
        end else k_d = k_q + IDX_W'(1);
      end
      // N MAC cycles (ck=0..N-1) then one write-back cycle (ck=N) per element.
      COMPUTE: if (ck_q == n_q) begin
        c_we = 1'b1;
        ck_d = '0;
        if (cj_q == n_m1) begin
          cj_d = '0;
          if (ci_q == n_m1) begin
            ci_d     = '0;
            elem_d   = '0;
            byte_d   = '0;
            chk_d    = '0;
            chk_ph_d = 1'b0;
            last_d   = 1'b0;
            state_d  = SEND;
          end else ci_d = ci_q + N_W'(1);
        end else cj_d = cj_q + N_W'(1);
      end else begin
        acc_d = ((ck_q == '0) ? '0 : acc_q) + ACC_W'(prod);
        ck_d  = ck_q + N_W'(1);
      end
      SEND: if (!bus.tx_busy) begin
        tx_start_d = 1'b1;
        first_d    = 1'b1;
        state_d    = SEND_WAIT;
        if (chk_ph_q) begin
          tx_data_d = chk_q;
          last_d    = 1'b1;
        end else begin
          tx_data_d = res_byte;
          chk_d     = chk_q ^ res_byte;
          if (byte_q == BYTE_LAST) begin
            byte_d = '0;
            if (elem_q == nn_m1) begin
`ifdef MSE_CHECKSUM_EN
              chk_ph_d = 1'b1;
`else
              last_d = 1'b1;
`endif
            end else elem_d = elem_q + IDX_W'(1);
          end else byte_d = byte_q + B_W'(1);
        end
      end
      // The transmitter raises tx_busy a cycle after tx_start, so the first cycle is skipped.
      SEND_WAIT: if (first_q) begin
        first_d = 1'b0;
      end else if (!bus.tx_busy) begin
        if (last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      ci_q       <= '0;
      cj_q       <= '0;
      ck_q       <= '0;
      acc_q      <= '0;
      elem_q     <= '0;
      byte_q     <= '0;
      chk_q      <= '0;
      chk_ph_q   <= 1'b0;
      last_q     <= 1'b0;
      first_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      ci_q       <= ci_d;
      cj_q       <= cj_d;
      ck_q       <= ck_d;
      acc_q      <= acc_d;
      elem_q     <= elem_d;
      byte_q     <= byte_d;
      chk_q      <= chk_d;
      chk_ph_q   <= chk_ph_d;
      last_q     <= last_d;
      first_q    <= first_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (a_we) a_mem[k_q] <= bus.rx_data[DATA_W-1:0];
    if (b_we) b_mem[k_q] <= bus.rx_data[DATA_W-1:0];
    if (c_we) c_mem[c_idx] <= acc_q;
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.state    = state_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err_size = err_q;
  assign bus.done     = done_q;
endmodule
